cmos_capture_data: RTL and testbench

//  - Upstream of the LCD top: turns the OV7725 8-bit DVP stream into 16-bit RGB565 pixel writes.
//  - Output feeds the frame-buffer write side; the LCD top later reads it back through cmos_data/data_req.
//  - Discards the first WAIT_FRAME frames after camera config completes, so register settings have settled.
//  - Runs entirely in the camera pixel-clock domain.

---
 rtl/cmos_capture_data.sv | 206 ++++++++++++++++++++
 tb/tb_cmos_capture_data.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_data.sv
// cmos_capture_data: OV7725 8-bit DVP stream to RGB565 pixel strobes, camera pclk domain only.
// Optional size checking (frame_err) is compiled in when CMOS_LINE_CHECK_EN is defined.
module cmos_capture_data #(
  parameter int WAIT_FRAME = 10,
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480
) (
  input  logic        cam_pclk,
  input  logic        sys_rst_n,
  input  logic        cfg_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_valid,
  output logic [15:0] cmos_frame_data,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SKIP = 4'(WAIT_FRAME - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  frame_cnt;
  logic [3:0]  frame_cnt_nxt;
  logic        frame_ok;
  logic        frame_ok_nxt;

  logic        vsync_d0;
  logic        vsync_d1;
  logic        href_d0;
  logic        href_d1;
  logic [7:0]  data_d0;
  logic        vs_pos;

  logic        byte_flag;
  logic [7:0]  hi_byte;
  logic [15:0] pix_buf;
  logic        pix_done;
  logic        size_block;

  always_ff @(posedge cam_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d0 <= 1'b0;
      vsync_d1 <= 1'b0;
      href_d0  <= 1'b0;
      href_d1  <= 1'b0;
      data_d0  <= 8'd0;
    end else begin
      vsync_d0 <= cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= cam_href;
      href_d1  <= href_d0;
      data_d0  <= cam_data;
    end
  end

  assign vs_pos = vsync_d0 & ~vsync_d1;

  always_ff @(posedge cam_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      frame_cnt <= 4'd0;
      frame_ok  <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      frame_ok  <= frame_ok_nxt;
    end
  end

  // frame_ok only rises on a frame edge, so the first frame let through is whole.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    frame_ok_nxt  = frame_ok;
    case (state)
      IDLE: begin
        frame_ok_nxt = 1'b0;
        if (cfg_done) begin
          state_nxt     = SKIP;
          frame_cnt_nxt = 4'd0;
        end
      end
      SKIP: begin
        if (!cfg_done) begin
          state_nxt    = IDLE;
          frame_ok_nxt = 1'b0;
        end else if (vs_pos) begin
          frame_cnt_nxt = frame_cnt + 4'd1;
          if (frame_cnt == LAST_SKIP) begin
            state_nxt    = RUN;
            frame_ok_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (!cfg_done) begin
          state_nxt    = IDLE;
          frame_ok_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        frame_ok_nxt = 1'b0;
      end
    endcase
  end

  // First byte of a pair is the high byte; a trailing odd byte is lost when href drops.
  always_ff @(posedge cam_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_flag <= 1'b0;
      hi_byte   <= 8'd0;
      pix_buf   <= 16'd0;
      pix_done  <= 1'b0;
    end else if (href_d0) begin
      byte_flag <= ~byte_flag;
      pix_done  <= byte_flag;
      if (!byte_flag) begin
        hi_byte <= data_d0;
      end else begin
        pix_buf <= {hi_byte, data_d0};
      end
    end else begin
      byte_flag <= 1'b0;
      pix_done  <= 1'b0;
    end
  end

  always_ff @(posedge cam_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmos_frame_vsync <= 1'b0;
      cmos_frame_href  <= 1'b0;
      cmos_frame_valid <= 1'b0;
      cmos_frame_data  <= 16'd0;
    end else begin
      cmos_frame_vsync <= frame_ok & vsync_d1;
      cmos_frame_href  <= frame_ok & href_d1;
      cmos_frame_valid <= frame_ok & pix_done & ~size_block;
      if (pix_done) begin
        cmos_frame_data <= pix_buf;
      end
    end
  end

`ifdef CMOS_LINE_CHECK_EN
  logic [15:0] pix_cnt;
  logic [15:0] line_cnt;
  logic        href_fall;
  logic        line_bad;
  logic        err_pulse;

  assign href_fall  = href_d1 & ~href_d0;
  assign line_bad   = (line_cnt != 16'(V_PIXEL)) && (line_cnt != 16'd0);
  assign size_block = frame_err;

  // A short/long line latches frame_err until the next frame edge; a bad line
  // count found at the frame edge itself only pulses for one cycle.
  always_ff @(posedge cam_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_cnt   <= 16'd0;
      line_cnt  <= 16'd0;
      frame_err <= 1'b0;
      err_pulse <= 1'b0;
    end else if (vs_pos) begin
      pix_cnt   <= 16'd0;
      line_cnt  <= 16'd0;
      frame_err <= line_bad;
      err_pulse <= line_bad;
    end else if (href_fall) begin
      pix_cnt  <= 16'd0;
      line_cnt <= line_cnt + 16'd1;
      if (pix_cnt != 16'(H_PIXEL)) begin
        frame_err <= 1'b1;
        err_pulse <= 1'b0;
      end else if (err_pulse) begin
        frame_err <= 1'b0;
        err_pulse <= 1'b0;
      end
    end else begin
      if (href_d0 && byte_flag) begin
        pix_cnt <= pix_cnt + 16'd1;
      end
      if (err_pulse) begin
        frame_err <= 1'b0;
        err_pulse <= 1'b0;
      end
    end
  end
`else
  logic unused_params;

  assign unused_params = ^{16'(H_PIXEL), 16'(V_PIXEL)};
  assign size_block    = 1'b0;
  assign frame_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_capture_data.sv
// tb_cmos_capture_data: drives DVP frames, predicts RGB565 strobes with a frame-level model
// and a scoreboard queue (pixel value plus the pclk edge it must appear on).
module tb_cmos_capture_data;

  localparam int WAIT = 10;
  localparam int H    = 8;
  localparam int V    = 4;
`ifdef CMOS_LINE_CHECK_EN
  localparam bit LINE_CHECK = 1'b1;
`else
  localparam bit LINE_CHECK = 1'b0;
`endif

  logic        clk;
  logic        sys_rst_n;
  logic        cfg_done;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic        frame_err;

  logic [15:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          strobe_cnt = 0;
  logic        prev_valid = 1'b0;

  // frame-level model of the skip/run behaviour
  bit          model_armed = 1'b0;
  bit          model_ok = 1'b0;
  bit          model_err = 1'b0;
  int          skip_cnt = 0;

  cmos_capture_data #(
    .WAIT_FRAME(WAIT),
    .H_PIXEL   (H),
    .V_PIXEL   (V)
  ) dut (
    .cam_pclk        (clk),
    .sys_rst_n       (sys_rst_n),
    .cfg_done        (cfg_done),
    .cam_vsync       (cam_vsync),
    .cam_href        (cam_href),
    .cam_data        (cam_data),
    .cmos_frame_vsync(cmos_frame_vsync),
    .cmos_frame_href (cmos_frame_href),
    .cmos_frame_valid(cmos_frame_valid),
    .cmos_frame_data (cmos_frame_data),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest predicted pixel and its edge.
  always @(negedge clk) begin
    if (cmos_frame_valid) begin
      strobe_cnt++;
      check("b2b", prev_valid, 1'b0);
      if (exp_q.size() == 0) begin
        check("spur", cmos_frame_valid, 1'b0);
      end else begin
        check("pix", cmos_frame_data, exp_q.pop_front());
        check("lat", cyc, cyc_q.pop_front());
      end
    end
    prev_valid = cmos_frame_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cam_href  = 1'b0;
      cam_vsync = 1'b0;
      cam_data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    cam_href = 1'b1;
    cam_data = b;
  endtask

  task automatic raise_cfg();
    idle(3);
    cfg_done    = 1'b1;
    model_armed = 1'b1;
    model_ok    = 1'b0;
    skip_cnt    = 0;
    idle(3);
  endtask

  // event_kind: 0 none, 1 cfg_done drop, 2 async reset; fired mid-line at pixel H/2.
  task automatic send_frame(input int n_lines, input int short_line, input bit odd,
                            input bit fixed_first, input int event_line,
                            input int event_kind, input bit end_vsync);
    int npix;
    int pushed;
    logic [7:0] hi;
    logic [7:0] lo;
    pushed     = 0;
    strobe_cnt = 0;
    for (int ln = 0; ln < n_lines; ln++) begin
      npix = (ln == short_line) ? H - 1 : H;
      for (int p = 0; p < npix; p++) begin
        if (ln == event_line && p == H / 2 && event_kind == 1) begin
          // dropped before the next edge: the pair just completed never gets its strobe
          cfg_done    = 1'b0;
          model_ok    = 1'b0;
          model_armed = 1'b0;
          if (exp_q.size() > 0) begin
            exp_q.delete(exp_q.size() - 1);
            cyc_q.delete(cyc_q.size() - 1);
            pushed--;
          end
        end
        if (ln == event_line && p == H / 2 && event_kind == 2) begin
          #3 sys_rst_n = 1'b0;
          #1;
          check("arst_valid", cmos_frame_valid, 1'b0);
          check("arst_href", cmos_frame_href, 1'b0);
          check("arst_vsync", cmos_frame_vsync, 1'b0);
          check("arst_data", cmos_frame_data, 16'h0000);
          pushed      = pushed - exp_q.size();
          exp_q.delete();
          cyc_q.delete();
          model_ok    = 1'b0;
          model_err   = 1'b0;
          skip_cnt    = 0;
          drive_byte(8'($urandom_range(0, 255)));
          drive_byte(8'($urandom_range(0, 255)));
          sys_rst_n   = 1'b1;
          model_armed = cfg_done;
        end
        if (ln == event_line && p == H / 2 + 2 && event_kind == 1) begin
          check("cfg_off_href", cmos_frame_href, 1'b0);
          check("cfg_off_valid", cmos_frame_valid, 1'b0);
        end
        if (p == 2) check("href_out", cmos_frame_href, model_ok);
        hi = (fixed_first && ln == 0 && p == 0) ? 8'hF8 : 8'($urandom_range(0, 255));
        lo = (fixed_first && ln == 0 && p == 0) ? 8'h1F : 8'($urandom_range(0, 255));
        drive_byte(hi);
        drive_byte(lo);
        if (model_ok && !model_err) begin
          exp_q.push_back({hi, lo});
          cyc_q.push_back(cyc + 3);
          pushed++;
        end
      end
      if (odd) drive_byte(8'($urandom_range(0, 255)));
      idle(4);
      if (npix != H && LINE_CHECK) model_err = 1'b1;
      if (ln == short_line) check("err_set", frame_err, LINE_CHECK);
    end
    idle(2);
    if (short_line >= 0) check("err_hold", frame_err, LINE_CHECK);
    check("frame_strobes", strobe_cnt, pushed);
    check("drain", exp_q.size(), 0);
    if (end_vsync) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        if (i == 0) begin
          if (model_armed && !model_ok) begin
            skip_cnt++;
            if (skip_cnt == WAIT) model_ok = 1'b1;
          end
          model_err = 1'b0;
        end
        if (i == 3) check("vs_out", cmos_frame_vsync, model_ok);
      end
      idle(4);
      if (short_line >= 0) check("err_clr", frame_err, 1'b0);
    end
  endtask

  task automatic skip_group(input string tag);
    for (int f = 1; f <= WAIT + 2; f++) begin
      send_frame(V, -1, 1'b0, 1'b0, -1, 0, 1'b1);
      check(tag, strobe_cnt, (f > WAIT) ? H * V : 0);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cfg_done  = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cam_vsync = 1'($urandom_range(0, 1));
      cam_href  = 1'($urandom_range(0, 1));
      cam_data  = 8'($urandom_range(0, 255));
    end
    check("rst_valid", cmos_frame_valid, 1'b0);
    check("rst_href", cmos_frame_href, 1'b0);
    check("rst_vsync", cmos_frame_vsync, 1'b0);
    check("rst_data", cmos_frame_data, 16'h0000);
    check("rst_err", frame_err, 1'b0);
    idle(1);
    sys_rst_n = 1'b1;
    idle(4);

    // cfg_done low: nothing may come out
    send_frame(V, -1, 1'b0, 1'b0, -1, 0, 1'b1);
    send_frame(V, -1, 1'b0, 1'b0, -1, 0, 1'b1);

    raise_cfg();
    skip_group("skip_first");

    send_frame(V, -1, 1'b0, 1'b1, -1, 0, 1'b1);
    send_frame(V, -1, 1'b1, 1'b0, -1, 0, 1'b1);
    check("odd_strobes", strobe_cnt, H * V);
    send_frame(V, 1, 1'b0, 1'b0, -1, 0, 1'b1);

    send_frame(V, -1, 1'b0, 1'b0, 1, 1, 1'b0);
    raise_cfg();
    skip_group("skip_recfg");

    send_frame(V, -1, 1'b0, 1'b0, 2, 2, 1'b0);
    idle(4);
    skip_group("skip_arst");

    idle(8);
    check("final_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: observed timeout at cycle %0d, expected completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
